// File: rtl/button_event_arbiter.sv
// Push-button front end: per-button synchronizer and debounce FSM that raise PRESS/RELEASE/LONG
// events, merged by a round-robin arbiter onto a single valid/ready event stream.
module button_event_arbiter #(
  parameter int unsigned N_BTN       = 4,
  parameter int unsigned DB_CYCLES   = 65535,
  parameter int unsigned LONG_CYCLES = 12000000,
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned ID_W        = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] btn_level,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [ID_W-1:0]  evt_btn,
  output logic [1:0]       evt_kind,
  output logic [N_BTN-1:0] evt_ovf
);

  localparam logic [1:0] KindPress   = 2'b01;
  localparam logic [1:0] KindRelease = 2'b10;
  localparam logic [1:0] KindLong    = 2'b11;

  localparam logic [CNT_W-1:0] DbLast   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LongSat  = CNT_W'(LONG_CYCLES);

  typedef enum logic [1:0] {StReleased, StPressWait, StPressed, StReleaseWait} state_e;

  logic [N_BTN-1:0] pend_v;
  logic [1:0]       pend_kind [N_BTN];
  logic [N_BTN-1:0] grant;
  logic             load;
  logic             gnt_found;
  logic [ID_W-1:0]  gnt_idx;
  logic [1:0]       gnt_kind;
  logic [ID_W-1:0]  rr_q;
  logic [ID_W-1:0]  idx;
  int               idx_n;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    logic             sync_q, s_q;
    state_e           st_q;
    logic [CNT_W-1:0] cnt_q, rel_cnt_q;
    logic             long_done_q, level_q;
    logic             raise;
    logic [1:0]       raise_kind;
    logic             pv_q, ovf_q;
    logic [1:0]       pk_q;

    always_comb begin
      raise      = 1'b0;
      raise_kind = 2'b00;
      case (st_q)
        StPressWait: begin
          if (s_q && cnt_q == DbLast) begin
            raise      = 1'b1;
            raise_kind = KindPress;
          end
        end
        StPressed: begin
          if (s_q && !long_done_q && cnt_q >= LongLast) begin
            raise      = 1'b1;
            raise_kind = KindLong;
          end
        end
        StReleaseWait: begin
          if (!s_q && rel_cnt_q == DbLast) begin
            raise      = 1'b1;
            raise_kind = KindRelease;
          end
        end
        default: ;
      endcase
    end

    // cnt measures hold time since PRESS and keeps running through a release glitch.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q      <= 1'b0;
        s_q         <= 1'b0;
        st_q        <= StReleased;
        cnt_q       <= '0;
        rel_cnt_q   <= '0;
        long_done_q <= 1'b0;
        level_q     <= 1'b0;
      end else begin
        sync_q <= btn[i];
        s_q    <= sync_q;
        case (st_q)
          StReleased: begin
            if (s_q) begin
              st_q  <= StPressWait;
              cnt_q <= CNT_W'(1);
            end
          end
          StPressWait: begin
            if (!s_q) begin
              st_q  <= StReleased;
              cnt_q <= '0;
            end else if (cnt_q == DbLast) begin
              st_q        <= StPressed;
              cnt_q       <= '0;
              level_q     <= 1'b1;
              long_done_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StPressed: begin
            if (cnt_q != LongSat) cnt_q <= cnt_q + 1'b1;
            if (!s_q) begin
              st_q      <= StReleaseWait;
              rel_cnt_q <= CNT_W'(1);
            end else if (raise) begin
              long_done_q <= 1'b1;
            end
          end
          StReleaseWait: begin
            if (cnt_q != LongSat) cnt_q <= cnt_q + 1'b1;
            if (s_q) begin
              st_q      <= StPressed;
              rel_cnt_q <= '0;
            end else if (rel_cnt_q == DbLast) begin
              st_q        <= StReleased;
              level_q     <= 1'b0;
              cnt_q       <= '0;
              rel_cnt_q   <= '0;
              long_done_q <= 1'b0;
            end else begin
              rel_cnt_q <= rel_cnt_q + 1'b1;
            end
          end
          default: st_q <= StReleased;
        endcase
      end
    end

    // A full slot only accepts a new event when it is being granted on this same edge.
    always_ff @(posedge clk) begin
      if (rst) begin
        pv_q  <= 1'b0;
        pk_q  <= 2'b00;
        ovf_q <= 1'b0;
      end else if (raise) begin
        if (pv_q && !grant[i]) begin
          ovf_q <= 1'b1;
        end else begin
          pv_q <= 1'b1;
          pk_q <= raise_kind;
        end
      end else if (grant[i]) begin
        pv_q <= 1'b0;
      end
    end

    assign btn_level[i] = level_q;
    assign evt_ovf[i]   = ovf_q;
    assign pend_v[i]    = pv_q;
    assign pend_kind[i] = pk_q;
  end

  // Search starts one past the last granted index.
  always_comb begin
    load      = !evt_valid || evt_ready;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_kind  = 2'b00;
    idx_n     = 0;
    idx       = '0;
    for (int k = 1; k <= int'(N_BTN); k++) begin
      idx_n = (int'(rr_q) + k) % int'(N_BTN);
      idx   = ID_W'(idx_n);
      if (!gnt_found && pend_v[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
        gnt_kind  = pend_kind[idx];
      end
    end
    grant = (load && gnt_found) ? (N_BTN'(1) << gnt_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_btn   <= '0;
      evt_kind  <= 2'b00;
      rr_q      <= '0;
    end else if (load) begin
      evt_valid <= gnt_found;
      if (gnt_found) begin
        evt_btn  <= gnt_idx;
        evt_kind <= gnt_kind;
        rr_q     <= gnt_idx;
      end
    end
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Randomized and directed bench for button_event_arbiter against a cycle-level behavioural model.
module tb_button_event_arbiter;
  localparam int N    = 4;
  localparam int DB   = 4;
  localparam int LONG = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic [3:0] btn_level;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_btn;
  logic [1:0] evt_kind;
  logic [3:0] evt_ovf;

  int n_checks = 0;
  int n_bad    = 0;

  // Model: sync pipe, debounced level, run of opposite samples, hold time, slots, output.
  int m_b1[N], m_b2[N], m_lvl[N], m_run[N], m_h[N], m_ldone[N];
  int m_pv[N], m_pk[N], m_ovf[N];
  int m_ov, m_ob, m_ok, m_rr;

  int n_kind[4];
  int evq[$];

  button_event_arbiter #(
    .N_BTN      (4),
    .DB_CYCLES  (4),
    .LONG_CYCLES(10),
    .CNT_W      (24),
    .ID_W       (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn      (btn),
    .btn_level(btn_level),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_btn  (evt_btn),
    .evt_kind (evt_kind),
    .evt_ovf  (evt_ovf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int gnt, idx, s, ev, r0;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_b1[i] = 0; m_b2[i] = 0; m_lvl[i] = 0; m_run[i] = 0; m_h[i] = 0; m_ldone[i] = 0;
        m_pv[i] = 0; m_pk[i] = 0; m_ovf[i] = 0;
      end
      m_ov = 0; m_ob = 0; m_ok = 0; m_rr = 0;
      return;
    end
    gnt = -1;
    if (!m_ov || evt_ready) begin
      for (int k = 1; k <= N; k++) begin
        idx = (m_rr + k) % N;
        if (gnt < 0 && m_pv[idx] != 0) gnt = idx;
      end
      if (gnt >= 0) begin
        m_ov = 1; m_ob = gnt; m_ok = m_pk[gnt]; m_rr = gnt;
      end else begin
        m_ov = 0;
      end
    end
    for (int i = 0; i < N; i++) begin
      s = m_b2[i];
      m_b2[i] = m_b1[i];
      m_b1[i] = int'(btn[i]);
      ev = 0;
      r0 = m_run[i];
      m_run[i] = (s != m_lvl[i]) ? m_run[i] + 1 : 0;
      if (m_lvl[i] != 0 && m_h[i] < 1000) m_h[i]++;
      if (m_run[i] == DB) begin
        m_lvl[i] = s; m_run[i] = 0; m_h[i] = 0; m_ldone[i] = 0;
        ev = (s != 0) ? 1 : 2;
      end else if (m_lvl[i] != 0 && r0 == 0 && s != 0 && m_h[i] >= LONG && m_ldone[i] == 0) begin
        ev = 3; m_ldone[i] = 1;
      end
      if (ev != 0) begin
        if (m_pv[i] != 0 && gnt != i) m_ovf[i] = 1;
        else begin
          m_pv[i] = 1; m_pk[i] = ev;
        end
      end else if (gnt == i) begin
        m_pv[i] = 0;
      end
    end
  endtask

  task automatic step();
    logic [3:0] lv, ov;
    if (evt_valid === 1'b1 && evt_ready === 1'b1 && rst === 1'b0) begin
      n_kind[evt_kind]++;
      evq.push_back(int'(evt_btn));
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      lv[i] = (m_lvl[i] != 0);
      ov[i] = (m_ovf[i] != 0);
    end
    check_eq("btn_level", btn_level, lv);
    check_eq("evt_valid", evt_valid, m_ov);
    check_eq("evt_btn", evt_btn, m_ob);
    check_eq("evt_kind", evt_kind, m_ok);
    check_eq("evt_ovf", evt_ovf, ov);
  endtask

  task automatic do_reset(input logic [3:0] b);
    rst = 1'b1;
    btn = b;
    repeat (3) step();
    rst = 1'b0;
    evq.delete();
    for (int k = 0; k < 4; k++) n_kind[k] = 0;
  endtask

  initial begin
    int q0, q1, q2;
    rst = 1'b1; btn = '0; evt_ready = 1'b1;

    // Reset with all buttons held, then the first PRESS must not come early.
    do_reset(4'b1111);
    for (int c = 0; c < 6; c++) begin
      step();
      check_eq("t1_no_early", evt_valid, 0);
    end
    step();
    check_eq("t1_valid", evt_valid, 1);
    check_eq("t1_kind", evt_kind, 1);
    check_eq("t1_btn", evt_btn, 1);
    btn = '0;
    repeat (12) step();

    // Clean press on button 1, then a single LONG.
    do_reset(4'b0000);
    btn[1] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      check_eq("t2_wait", evt_valid, 0);
    end
    step();
    check_eq("t2_valid", evt_valid, 1);
    check_eq("t2_btn", evt_btn, 1);
    check_eq("t2_kind", evt_kind, 1);
    check_eq("t2_level", btn_level[1], 1);
    for (int c = 0; c < 9; c++) begin
      step();
      check_eq("t2_gap", evt_valid, 0);
    end
    step();
    check_eq("t2_long_valid", evt_valid, 1);
    check_eq("t2_long_kind", evt_kind, 3);
    repeat (15) step();
    check_eq("t2_long_once", n_kind[3], 1);
    check_eq("t2_press_once", n_kind[1], 1);

    // Bounce on button 0.
    btn = '0;
    do_reset(4'b0000);
    for (int c = 0; c < 4; c++) begin
      btn[0] = (c % 2 == 0);
      step();
      check_eq("t3_bounce", evt_valid, 0);
    end
    btn[0] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      check_eq("t3_wait", evt_valid, 0);
    end
    step();
    check_eq("t3_valid", evt_valid, 1);
    check_eq("t3_kind", evt_kind, 1);
    check_eq("t3_btn", evt_btn, 0);

    // Glitch while holding button 2.
    btn = '0;
    do_reset(4'b0000);
    btn[2] = 1'b1;
    repeat (6) step();
    btn[2] = 1'b0;
    repeat (2) step();
    btn[2] = 1'b1;
    repeat (8) step();
    check_eq("t4_quiet", evt_valid, 0);
    step();
    check_eq("t4_long_valid", evt_valid, 1);
    check_eq("t4_long_kind", evt_kind, 3);
    check_eq("t4_long_btn", evt_btn, 2);
    repeat (10) step();
    check_eq("t4_no_release", n_kind[2], 0);
    check_eq("t4_one_long", n_kind[3], 1);
    check_eq("t4_one_press", n_kind[1], 1);

    // Round-robin: buttons 0, 1, 3 accepted together with rr=0.
    btn = '0;
    do_reset(4'b0000);
    btn = 4'b1011;
    repeat (11) step();
    check_eq("t5_count", evq.size(), 3);
    q0 = (evq.size() > 0) ? evq[0] : -1;
    q1 = (evq.size() > 1) ? evq[1] : -1;
    q2 = (evq.size() > 2) ? evq[2] : -1;
    check_eq("t5_first", q0, 1);
    check_eq("t5_second", q1, 3);
    check_eq("t5_third", q2, 0);

    // Backpressure and overflow on button 0.
    btn = '0;
    do_reset(4'b0000);
    evt_ready = 1'b0;
    btn[0] = 1'b1;
    repeat (7) step();
    check_eq("t6_press_out", evt_kind, 1);
    btn[0] = 1'b0;
    repeat (6) step();
    btn[0] = 1'b1;
    repeat (6) step();
    check_eq("t6_ovf", evt_ovf[0], 1);
    check_eq("t6_hold_valid", evt_valid, 1);
    check_eq("t6_hold_kind", evt_kind, 1);
    check_eq("t6_hold_btn", evt_btn, 0);
    evt_ready = 1'b1;
    step();
    check_eq("t6_release_out", evt_kind, 2);
    check_eq("t6_release_valid", evt_valid, 1);
    step();
    check_eq("t6_drained", evt_valid, 0);
    check_eq("t6_ovf_sticky", evt_ovf[0], 1);

    // Random traffic with occasional resets.
    btn = '0;
    do_reset(4'b0000);
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, (c < 750) ? 5 : 12) == 0) btn[i] = ~btn[i];
      end
      evt_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
